// File: rtl/core_pkg.sv
// Shared definitions for the RV32 R-type core: sequencer state encoding,
// opcode/ALU constants and the R-type legality check.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [6:0] OP_RTYPE   = 7'b0110011;
  localparam logic [3:0] ALU_MUL    = 4'b0110;
  localparam logic [6:0] FUNCT7_SUB = 7'd32;

  // Legality is judged here rather than trusting the decoder's output.
  function automatic logic is_illegal(input logic [31:0] instr);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = instr[14:12];
    f7 = instr[31:25];
    is_illegal = (instr[6:0] != OP_RTYPE) ||
                 (f3 == 3'b011) ||
                 ((f3 == 3'b000) && (f7 != 7'd0) && (f7 != FUNCT7_SUB));
  endfunction

endpackage

// File: rtl/exec_timer.sv
// 4-bit loadable down-counter used to stretch EXEC for multi-cycle units.
module exec_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_value,
  output logic [3:0] value,
  output logic       zero
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == 4'd0);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: fetch, decode-check, timed EXEC, single-cycle
// register write, with a sticky halt on unsupported encodings.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic [3:0]  dec_alu_control,
  input  logic        dec_write_en,
  output logic [3:0]  alu_control_q,
  output logic        alu_en,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        halted,
  output logic        illegal
);

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

  state_e      state_q;
  logic        we_q;
  logic        timer_load;
  logic        timer_dec;
  logic [3:0]  timer_load_value;
  logic [3:0]  timer_value;
  logic        timer_zero;

  // The timer is armed while DECODE hands over to EXEC; non-MUL ops get 0.
  assign timer_load       = (state_q == ST_DECODE);
  assign timer_load_value = (dec_alu_control == ALU_MUL) ? MUL_LOAD : 4'd0;
  assign timer_dec        = (state_q == ST_EXEC) && !timer_zero;

  exec_timer u_exec_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .dec        (timer_dec),
    .load_value (timer_load_value),
    .value      (timer_value),
    .zero       (timer_zero)
  );

  assign imem_addr = pc;

  // Sequencer state and its registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc            <= RESET_PC;
      ir            <= 32'd0;
      alu_control_q <= 4'd0;
      we_q          <= 1'b0;
      instret       <= 32'd0;
      imem_req      <= 1'b0;
      alu_en        <= 1'b0;
      rf_we         <= 1'b0;
      halted        <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q  <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            state_q  <= ST_DECODE;
            imem_req <= 1'b0;
          end
        end
        ST_DECODE: begin
          if (is_illegal(ir)) begin
            halted  <= 1'b1;
            illegal <= 1'b1;
            state_q <= ST_HALT;
          end else begin
            alu_control_q <= dec_alu_control;
            we_q          <= dec_write_en;
            alu_en        <= 1'b1;
            state_q       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (timer_value == 4'd0) begin
            alu_en  <= 1'b0;
            rf_we   <= we_q;
            state_q <= ST_WB;
          end
        end
        ST_WB: begin
          rf_we   <= 1'b0;
          pc      <= pc + 32'd4;
          instret <= instret + 32'd1;
          if (enable) begin
            state_q  <= ST_FETCH;
            imem_req <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q  <= ST_HALT;
          halted   <= 1'b1;
          imem_req <= 1'b0;
          alu_en   <= 1'b0;
          rf_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed, table-driven bench for core_sequencer plus hand-written corner sequences.
module tb_core_sequencer;
  import core_pkg::*;

  logic        clk;
  logic        rst_n, rst2_n;
  logic        enable;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata, ir, pc, instret;
  logic [3:0]  dec_alu_control, alu_control_q;
  logic        alu_en, rf_we, halted, illegal;

  logic        imem_req2, imem_ack2, alu_en2, rf_we2, halted2, illegal2;
  logic [31:0] imem_addr2, imem_rdata2, ir2, pc2, instret2;
  logic [3:0]  alu_control_q2;

  int checks = 0;
  int failures = 0;

  // Reference decoder driving the sequencer's decoder inputs.
  always_comb begin
    case (ir[14:12])
      3'b010:  dec_alu_control = ALU_MUL;
      3'b111:  dec_alu_control = 4'b0000;
      default: dec_alu_control = (ir[31:25] == FUNCT7_SUB) ? 4'b0011 : 4'b0010;
    endcase
  end

  core_sequencer #(.RESET_PC(32'h0000_0000), .MUL_LATENCY(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .dec_alu_control(dec_alu_control), .dec_write_en(1'b1),
    .alu_control_q(alu_control_q), .alu_en(alu_en), .rf_we(rf_we),
    .pc(pc), .instret(instret), .halted(halted), .illegal(illegal)
  );

  core_sequencer #(.RESET_PC(32'hFFFF_FFFC), .MUL_LATENCY(3)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .enable(enable),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .ir(ir2), .dec_alu_control(4'b0010), .dec_write_en(1'b1),
    .alu_control_q(alu_control_q2), .alu_en(alu_en2), .rf_we(rf_we2),
    .pc(pc2), .instret(instret2), .halted(halted2), .illegal(illegal2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Serves one instruction on dut's memory port; returns at the negedge of the rf_we cycle.
  task automatic run_instr(input logic [31:0] instr, input int waits, input int drop_at,
                           input logic [3:0] exp_code, output int lat, output int alu_n,
                           output int code_bad);
    int fetched;
    bit done;
    lat = 0; alu_n = 0; code_bad = 0; fetched = 0; done = 1'b0;
    for (int k = 0; k < 20 && !imem_req; k++) @(negedge clk);
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      if (cyc == drop_at) enable = 1'b0;
      imem_ack = 1'b0;
      if (imem_req) begin
        imem_ack   = (fetched == waits);
        imem_rdata = instr;
        fetched++;
      end
      if (alu_en) alu_n++;
      if ((alu_en || rf_we) && (alu_control_q !== exp_code)) code_bad++;
      if (rf_we) begin
        lat  = cyc;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    imem_ack = 1'b0;
  endtask

  typedef struct {
    logic [31:0] instr;
    int          waits;
    int          exp_lat;
    int          exp_alu;
    logic [3:0]  exp_code;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] exp_pc;
  logic [31:0] exp_instret;
  int          lat, alu_n, code_bad, seen;

  initial begin
    vecs[0] = '{32'h0020_8033, 0, 4, 1, 4'b0010};  // ADD
    vecs[1] = '{32'h0020_A033, 0, 6, 3, 4'b0110};  // MUL
    vecs[2] = '{32'h4020_8033, 2, 6, 1, 4'b0011};  // SUB, 2 wait states
    vecs[3] = '{32'h0020_A033, 1, 7, 3, 4'b0110};  // MUL, 1 wait state
    vecs[4] = '{32'h0020_F033, 0, 4, 1, 4'b0000};  // AND

    rst_n = 1'b0; rst2_n = 1'b0; enable = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'd0; imem_ack2 = 1'b0; imem_rdata2 = 32'd0;
    @(negedge clk); @(negedge clk);
    chk("rst_pc", pc, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_outs", {27'd0, imem_req, alu_en, rf_we, halted, illegal}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_wrap_pc", pc2, 32'hFFFF_FFFC);

    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req", {31'd0, imem_req}, 32'd0);
    enable = 1'b1;
    @(negedge clk);
    chk("fetch_req_cycle1", {31'd0, imem_req}, 32'd1);

    exp_pc = 32'd0; exp_instret = 32'd0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("v%0d_addr", i), imem_addr, exp_pc);
      run_instr(vecs[i].instr, vecs[i].waits, 0, vecs[i].exp_code, lat, alu_n, code_bad);
      exp_pc = exp_pc + 32'd4;
      exp_instret = exp_instret + 32'd1;
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_alu_cycles", i), alu_n, vecs[i].exp_alu);
      chk($sformatf("v%0d_alu_code", i), code_bad, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_we_single", i), {31'd0, rf_we}, 32'd0);
      chk($sformatf("v%0d_pc", i), pc, exp_pc);
      chk($sformatf("v%0d_instret", i), instret, exp_instret);
      chk($sformatf("v%0d_refetch", i), {31'd0, imem_req}, 32'd1);
    end

    // Enable drops in cycle 2 of a 5-wait fetch: request held, instruction retires, then IDLE.
    run_instr(32'h0020_8033, 5, 2, 4'b0010, lat, alu_n, code_bad);
    chk("drop_latency", lat, 32'd9);
    exp_pc = exp_pc + 32'd4;
    @(negedge clk);
    chk("drop_pc", pc, exp_pc);
    chk("drop_idle_req", {31'd0, imem_req}, 32'd0);
    repeat (3) @(negedge clk);
    chk("drop_stays_idle", {31'd0, imem_req}, 32'd0);

    // Retire one ADD, start a MUL and reset in its 2nd EXEC cycle.
    enable = 1'b1;
    @(negedge clk);
    run_instr(32'h0020_8033, 0, 0, 4'b0010, lat, alu_n, code_bad);
    @(negedge clk);
    chk("pre_rst_instret", instret, exp_instret + 32'd2);
    imem_ack = 1'b1; imem_rdata = 32'h0020_A033;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mul_exec2_alu_en", {31'd0, alu_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {27'd0, imem_req, alu_en, rf_we, halted, illegal}, 32'd0);
    chk("async_rst_pc", pc, 32'd0);
    chk("async_rst_instret", instret, 32'd0);
    chk("async_rst_aluq", {28'd0, alu_control_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6 && !imem_req; k++) begin
      if (rf_we) seen++;
      @(negedge clk);
    end
    chk("rst_no_we", seen, 32'd0);
    chk("restart_addr", {imem_req, imem_addr[30:0]}, {1'b1, 31'd0});

    // Illegal I-type encoding halts; later acks are ignored.
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk);
    chk("ill_flags", {30'd0, halted, illegal}, 32'd3);
    chk("ill_pc", pc, 32'd0);
    seen = 0;
    imem_ack = 1'b1; imem_rdata = 32'h0020_8033;
    for (int k = 0; k < 5; k++) begin
      if (rf_we || imem_req || alu_en) seen++;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    chk("ill_absorbing", seen, 32'd0);
    chk("ill_ir_kept", ir, 32'h0000_0013);
    chk("ill_pc_kept", pc, 32'd0);
    chk("ill_instret", instret, 32'd0);

    // PC wrap from 0xFFFF_FFFC on the second instance.
    rst2_n = 1'b1;
    for (int k = 0; k < 5 && !imem_req2; k++) @(negedge clk);
    chk("wrap_first_addr", imem_addr2, 32'hFFFF_FFFC);
    imem_ack2 = 1'b1; imem_rdata2 = 32'h0020_8033;
    @(negedge clk); imem_ack2 = 1'b0;
    for (int k = 0; k < 10 && !rf_we2; k++) @(negedge clk);
    chk("wrap_we", {31'd0, rf_we2}, 32'd1);
    @(negedge clk);
    chk("wrap_pc", pc2, 32'd0);
    chk("wrap_addr", {imem_req2, imem_addr2[30:0]}, {1'b1, 31'd0});
    chk("wrap_instret", instret2, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
